mem_arbiter: RTL

Single-port memory arbiter between the pipeline's instruction-fetch port and data port. It sits between the fetch/memory stages and the unified RAM, and grants one requester at a time. Data accesses have priority, and a bounded-streak rule prevents fetch starvation. It also sequences the halt drain and keeps access counters for bench and statistics use.

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data ports.
// Data has priority, with a bounded streak so a pending fetch is never starved.
module mem_arbiter #(
    parameter int unsigned MAX_DSTREAK = 4,
    parameter logic [31:0] ERR_WORD    = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    input  logic        halt,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        halted,
    output logic        err_flag,
    output logic [15:0] icount,
    output logic [15:0] dcount
);

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT, HALTED} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    state_t      state;
    logic [3:0]  streak;
    logic        dreq;
    logic        i_live;
    logic        d_live;
    logic        resp;
    logic        i_done;
    logic        d_done;
    logic [31:0] rd_data;

    // A grant is only live while its requester still asserts; dropping it aborts.
    assign dreq    = dREN | dWEN;
    assign i_live  = (state == IGRANT) && iREN;
    assign d_live  = (state == DGRANT) && dreq;
    assign resp    = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);
    assign i_done  = i_live && resp;
    assign d_done  = d_live && resp;
    assign rd_data = (ramstate == RAM_ERROR) ? ERR_WORD : ramload;
    assign halted  = (state == HALTED);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        iwait    = iREN && !i_done;
        dwait    = dreq && !d_done;
        if (i_live) begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (resp) iload = rd_data;
        end
        if (d_live) begin
            ramREN   = !dWEN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (resp) dload = rd_data;
        end
        if (state == HALTED) begin
            iwait = 1'b1;
            dwait = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            streak   <= '0;
            icount   <= '0;
            dcount   <= '0;
            err_flag <= 1'b0;
        end else begin
            if (!iREN || i_done)
                streak <= '0;
            else if (d_done && streak != 4'hF)
                streak <= streak + 4'd1;

            if (i_done) icount <= icount + 16'd1;
            if (d_done) dcount <= dcount + 16'd1;
            if ((i_done || d_done) && ramstate == RAM_ERROR) err_flag <= 1'b1;

            case (state)
                IDLE: begin
                    if (halt)
                        state <= HALTED;
                    else if (dreq && !(iREN && streak >= STREAK_MAX))
                        state <= DGRANT;
                    else if (iREN)
                        state <= IGRANT;
                end
                IGRANT: begin
                    if (!iREN)
                        state <= IDLE;
                    else if (i_done)
                        state <= halt ? HALTED : IDLE;
                end
                DGRANT: begin
                    if (!dreq)
                        state <= IDLE;
                    else if (d_done)
                        state <= halt ? HALTED : IDLE;
                end
                default: state <= HALTED;
            endcase
        end
    end

endmodule
